keypad_input: RTL

//  Front-end stage directly upstream of the controller: scans a 4x5 key matrix, debounces it,

---
 rtl/keypad_input_pkg.sv | 58 +++++
 rtl/keypad_input_keymap.sv | 43 ++++
 rtl/keypad_input.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/keypad_input_pkg.sv
//==============================================================================
// Module   : keypad_input_pkg
// Brief    : Matrix geometry, controller command codes and row-scan helpers.
// Revision : 1.0
//==============================================================================
`default_nettype none

package keypad_input_pkg;

    localparam int KP_ROWS = 4;
    localparam int KP_COLS = 5;
    localparam int IC_N    = 5;

    localparam logic [IC_N-1:0] IC_NONE = 5'd0;
    localparam logic [IC_N-1:0] IC_NUM0 = 5'd1;
    localparam logic [IC_N-1:0] IC_NUM1 = 5'd2;
    localparam logic [IC_N-1:0] IC_NUM2 = 5'd3;
    localparam logic [IC_N-1:0] IC_NUM3 = 5'd4;
    localparam logic [IC_N-1:0] IC_NUM4 = 5'd5;
    localparam logic [IC_N-1:0] IC_NUM5 = 5'd6;
    localparam logic [IC_N-1:0] IC_NUM6 = 5'd7;
    localparam logic [IC_N-1:0] IC_NUM7 = 5'd8;
    localparam logic [IC_N-1:0] IC_NUM8 = 5'd9;
    localparam logic [IC_N-1:0] IC_NUM9 = 5'd10;
    localparam logic [IC_N-1:0] IC_EXAD = 5'd11;
    localparam logic [IC_N-1:0] IC_EXSB = 5'd12;
    localparam logic [IC_N-1:0] IC_EXMU = 5'd13;
    localparam logic [IC_N-1:0] IC_EXDI = 5'd14;
    localparam logic [IC_N-1:0] IC_EXLP = 5'd15;
    localparam logic [IC_N-1:0] IC_EXRP = 5'd16;
    localparam logic [IC_N-1:0] IC_EXEQ = 5'd17;
    localparam logic [IC_N-1:0] IC_CLBK = 5'd18;
    localparam logic [IC_N-1:0] IC_CLCL = 5'd19;

    function automatic logic [2:0] count_low(input logic [KP_ROWS-1:0] rows);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < KP_ROWS; i++) begin
            n = n + {2'b00, ~rows[i]};
        end
        return n;
    endfunction

    // Index of the lowest active (low) row; only meaningful when exactly one is low.
    function automatic logic [1:0] low_row(input logic [KP_ROWS-1:0] rows);
        logic [1:0] r;
        r = '0;
        for (int i = KP_ROWS - 1; i >= 0; i--) begin
            if (!rows[i]) begin
                r = 2'(i);
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_input_keymap.sv
//==============================================================================
// Module   : keypad_keymap
// Brief    : Combinational ROM translating a key index into a controller command.
// Revision : 1.0
//==============================================================================
`default_nettype none

module keypad_keymap
    import keypad_input_pkg::*;
(
    input  logic [4:0]      key_idx,
    output logic [IC_N-1:0] cmd
);

    always_comb begin
        cmd = IC_NONE;
        case (key_idx)
            5'd0:    cmd = IC_NUM0;
            5'd1:    cmd = IC_NUM1;
            5'd2:    cmd = IC_NUM2;
            5'd3:    cmd = IC_NUM3;
            5'd4:    cmd = IC_NUM4;
            5'd5:    cmd = IC_NUM5;
            5'd6:    cmd = IC_NUM6;
            5'd7:    cmd = IC_NUM7;
            5'd8:    cmd = IC_NUM8;
            5'd9:    cmd = IC_NUM9;
            5'd10:   cmd = IC_EXAD;
            5'd11:   cmd = IC_EXSB;
            5'd12:   cmd = IC_EXMU;
            5'd13:   cmd = IC_EXDI;
            5'd14:   cmd = IC_EXLP;
            5'd15:   cmd = IC_EXRP;
            5'd16:   cmd = IC_EXEQ;
            5'd17:   cmd = IC_CLBK;
            5'd18:   cmd = IC_CLCL;
            default: cmd = IC_NONE;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/keypad_input.sv
//==============================================================================
// Module   : keypad_input
// Brief    : 4x5 key matrix scanner with frame debounce and held command handshake.
// Revision : 1.0
//==============================================================================
`default_nettype none

module keypad_input
    import keypad_input_pkg::*;
#(
    parameter int SCAN_DIV   = 1000,
    parameter int DEBOUNCE_N = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [KP_ROWS-1:0] row_in,
    output logic [KP_COLS-1:0] col_out,
    input  logic               in_ack,
    output logic [IC_N-1:0]    in_cmd,
    output logic               key_lost
);

    localparam int         c_DIV_W = $clog2(SCAN_DIV);
    localparam logic [7:0] c_DEB   = 8'(DEBOUNCE_N);

    localparam logic [1:0] c_ST_SCAN    = 2'd0;
    localparam logic [1:0] c_ST_CONFIRM = 2'd1;
    localparam logic [1:0] c_ST_HELD    = 2'd2;
    localparam logic [1:0] c_ST_RELEASE = 2'd3;

    logic [c_DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]         col_q, col_d;
    logic [3:0]         sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]         acc_cnt_q, acc_cnt_d;
    logic [4:0]         acc_key_q, acc_key_d;
    logic [1:0]         state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [4:0]         cand_q, cand_d;
    logic               emit_q, emit_d;
    logic [IC_N-1:0]    in_cmd_q, in_cmd_d;
    logic               key_lost_q, key_lost_d;

    logic               w_sample_en, w_frame_end, w_single, w_none;
    logic [2:0]         w_sum;
    logic [1:0]         w_frame_cnt;
    logic [4:0]         w_frame_key, w_new_key;
    logic [7:0]         w_cnt_inc;
    logic [IC_N-1:0]    w_map;

    keypad_keymap u_keymap (
        .key_idx (cand_q),
        .cmd     (w_map)
    );

    // Scan timing, synchroniser and per-frame low-bit accumulation.
    always_comb begin
        w_sample_en = (div_cnt_q == c_DIV_W'(SCAN_DIV - 1));
        w_frame_end = w_sample_en && (col_q == 3'd4);
        div_cnt_d   = w_sample_en ? '0 : div_cnt_q + c_DIV_W'(1);
        col_d       = col_q;
        if (w_sample_en) begin
            col_d = (col_q == 3'd4) ? 3'd0 : col_q + 3'd1;
        end
        sync1_d     = row_in;
        sync2_d     = sync1_q;
        w_sum       = {1'b0, acc_cnt_q} + count_low(sync2_q);
        w_frame_cnt = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
        w_new_key   = 5'(low_row(sync2_q)) * 5'd5 + 5'(col_q);
        w_frame_key = (acc_cnt_q == 2'd1) ? acc_key_q : w_new_key;
        acc_cnt_d   = acc_cnt_q;
        acc_key_d   = acc_key_q;
        if (w_sample_en) begin
            acc_cnt_d = w_frame_end ? 2'd0 : w_frame_cnt;
            acc_key_d = w_frame_end ? 5'd0 : w_frame_key;
        end
        w_single  = w_frame_end && (w_frame_cnt == 2'd1);
        w_none    = w_frame_end && (w_frame_cnt == 2'd0);
        w_cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    end

    always_comb begin
        col_out = 5'b11111;
        case (col_q)
            3'd0:    col_out = 5'b11110;
            3'd1:    col_out = 5'b11101;
            3'd2:    col_out = 5'b11011;
            3'd3:    col_out = 5'b10111;
            3'd4:    col_out = 5'b01111;
            default: col_out = 5'b11110;
        endcase
    end

    // Debounce FSM: next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        if (w_frame_end) begin
            case (state_q)
                c_ST_SCAN: begin
                    if (w_single) begin
                        state_d = c_ST_CONFIRM;
                        cand_d  = w_frame_key;
                        cnt_d   = 8'd1;
                    end
                end
                c_ST_CONFIRM: begin
                    if (w_single && (w_frame_key == cand_q)) begin
                        cnt_d = w_cnt_inc;
                        if (w_cnt_inc == c_DEB) begin
                            state_d = c_ST_HELD;
                        end
                    end else begin
                        state_d = c_ST_SCAN;
                        cnt_d   = 8'd0;
                    end
                end
                c_ST_HELD: begin
                    if (w_none) begin
                        state_d = c_ST_RELEASE;
                        cnt_d   = 8'd1;
                    end
                end
                c_ST_RELEASE: begin
                    if (w_none) begin
                        cnt_d = w_cnt_inc;
                        if (w_cnt_inc == c_DEB) begin
                            state_d = c_ST_SCAN;
                        end
                    end else begin
                        state_d = c_ST_HELD;
                    end
                end
                default: state_d = c_ST_SCAN;
            endcase
        end
    end

    // Debounce FSM: outputs. cand_q stays valid in HELD, so it addresses the map during EMIT.
    always_comb begin
        emit_d = w_frame_end && (state_q == c_ST_CONFIRM) && w_single
                 && (w_frame_key == cand_q) && (w_cnt_inc == c_DEB);
    end

    always_comb begin
        in_cmd_d   = in_cmd_q;
        key_lost_d = key_lost_q;
        if (in_ack && (in_cmd_q != IC_NONE)) begin
            in_cmd_d = IC_NONE;
        end
        if (emit_q && (w_map != IC_NONE)) begin
            if (in_cmd_q == IC_NONE) begin
                in_cmd_d   = w_map;
                key_lost_d = 1'b0;
            end else if (!in_ack) begin
                key_lost_d = 1'b1;
            end else begin
                in_cmd_d = w_map;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q  <= '0;
            col_q      <= 3'd0;
            sync1_q    <= 4'hF;
            sync2_q    <= 4'hF;
            acc_cnt_q  <= 2'd0;
            acc_key_q  <= 5'd0;
            state_q    <= c_ST_SCAN;
            cnt_q      <= 8'd0;
            cand_q     <= 5'd0;
            emit_q     <= 1'b0;
            in_cmd_q   <= IC_NONE;
            key_lost_q <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            col_q      <= col_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            acc_cnt_q  <= acc_cnt_d;
            acc_key_q  <= acc_key_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cand_q     <= cand_d;
            emit_q     <= emit_d;
            in_cmd_q   <= in_cmd_d;
            key_lost_q <= key_lost_d;
        end
    end

    assign in_cmd   = in_cmd_q;
    assign key_lost = key_lost_q;

endmodule

`default_nettype wire
